// File: rtl/inst_mem_resp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inst_mem_resp_pkg                                                    |
// | Shared state encoding and constants for the instruction fetch path.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package inst_mem_resp_pkg;

  // Address width follows MAX_BIT_POS of the core configuration.
  localparam int c_max_bit_pos = 31;
  localparam int c_addr_w = c_max_bit_pos + 1;
  localparam int c_word_w = c_addr_w - 2;

  localparam logic [31:0] c_nop_word = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
`ifdef INST_PREFETCH_EN
    ,
    PREF  = 2'd3
`endif
  } state_t;

endpackage
`default_nettype wire

// File: rtl/inst_prefetch_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inst_prefetch_buf                                                    |
// | One-entry prefetch buffer: word tag, data word and valid flag.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module inst_prefetch_buf
  import inst_mem_resp_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                invalidate,
  input  logic [c_word_w-1:0] tag,
  input  logic [31:0]         data,
  input  logic [c_word_w-1:0] lookup_addr,
  output logic                hit,
  output logic [31:0]         rdata
);

  logic                r_valid;
  logic [c_word_w-1:0] r_tag;
  logic [31:0]         r_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (invalidate) begin
      r_valid <= 1'b0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_tag   <= tag;
      r_data  <= data;
    end
  end

  assign hit   = r_valid && (r_tag == lookup_addr);
  assign rdata = r_data;

endmodule
`default_nettype wire

// File: rtl/inst_mem_resp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inst_mem_resp                                                        |
// | Instruction fetch responder; INST_PREFETCH_EN adds next-word prefetch.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module inst_mem_resp
  import inst_mem_resp_pkg::*;
#(
  parameter int          MAX_WAIT = 255,
  parameter logic [31:0] NOP_WORD = c_nop_word
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_mem_read_en,
  input  logic [c_addr_w-1:0] inst_addr,
  output logic [31:0]         inst_data,
  output logic                inst_mem_ready,
  output logic                fetch_err,
  output logic                mem_req,
  output logic [31:0]         mem_addr,
  input  logic [31:0]         mem_rdata,
  input  logic                mem_ack
);

  localparam int c_wait_w = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(MAX_WAIT - 1);

  state_t              r_state, w_state_nxt;
  logic                r_mem_req, w_mem_req_nxt;
  logic [31:0]         r_mem_addr, w_mem_addr_nxt;
  logic [31:0]         r_data, w_data_nxt;
  logic                r_ready, w_ready_nxt;
  logic                r_err, w_err_nxt;
  logic [c_wait_w-1:0] r_wait, w_wait_nxt;
  logic                w_req_go;
  logic [c_addr_w-1:0] w_req_addr;

`ifdef INST_PREFETCH_EN
  logic [c_word_w-1:0] r_cur_word, w_cur_word_nxt;
  logic                r_ok, w_ok_nxt;
  logic                r_hit, w_hit_nxt;
  logic                r_pend, w_pend_nxt;
  logic [c_addr_w-1:0] r_pend_addr, w_pend_addr_nxt;
  logic                w_buf_hit, w_buf_load, w_buf_inv;
  logic [31:0]         w_buf_rdata;

  // A request latched during PREF is replayed from IDLE ahead of new ones.
  assign w_req_go   = r_pend | inst_mem_read_en;
  assign w_req_addr = r_pend ? r_pend_addr : inst_addr;

  inst_prefetch_buf u_buf (
    .clk         (clk),
    .rst         (rst),
    .load        (w_buf_load),
    .invalidate  (w_buf_inv),
    .tag         (r_mem_addr[c_addr_w-1:2]),
    .data        (mem_rdata),
    .lookup_addr (w_req_addr[c_addr_w-1:2]),
    .hit         (w_buf_hit),
    .rdata       (w_buf_rdata)
  );
`else
  assign w_req_go   = inst_mem_read_en;
  assign w_req_addr = inst_addr;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_mem_req_nxt  = r_mem_req;
    w_mem_addr_nxt = r_mem_addr;
    w_data_nxt     = r_data;
    w_ready_nxt    = r_ready;
    w_err_nxt      = 1'b0;
    w_wait_nxt     = r_wait;
`ifdef INST_PREFETCH_EN
    w_cur_word_nxt  = r_cur_word;
    w_ok_nxt        = r_ok;
    w_hit_nxt       = r_hit;
    w_pend_nxt      = r_pend;
    w_pend_addr_nxt = r_pend_addr;
    w_buf_load      = 1'b0;
    w_buf_inv       = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_req_go) begin
          w_ready_nxt = 1'b0;
`ifdef INST_PREFETCH_EN
          w_pend_nxt     = 1'b0;
          w_cur_word_nxt = w_req_addr[c_addr_w-1:2];
          w_ok_nxt       = 1'b0;
          w_hit_nxt      = 1'b0;
`endif
          if (w_req_addr[1:0] != 2'b00) begin
            w_data_nxt  = NOP_WORD;
            w_ready_nxt = 1'b1;
            w_err_nxt   = 1'b1;
            w_state_nxt = RESP;
          end
`ifdef INST_PREFETCH_EN
          else if (w_buf_hit) begin
            w_hit_nxt   = 1'b1;
            w_ok_nxt    = 1'b1;
            w_state_nxt = RESP;
          end
`endif
          else begin
            w_mem_req_nxt  = 1'b1;
            w_mem_addr_nxt = {w_req_addr[c_addr_w-1:2], 2'b00};
            w_wait_nxt     = '0;
            w_state_nxt    = FETCH;
          end
        end
      end
      FETCH: begin
        if (mem_ack) begin
          w_mem_req_nxt = 1'b0;
          w_data_nxt    = mem_rdata;
          w_ready_nxt   = 1'b1;
          w_state_nxt   = RESP;
`ifdef INST_PREFETCH_EN
          w_ok_nxt      = 1'b1;
`endif
        end else if (r_wait == c_wait_last) begin
          w_mem_req_nxt = 1'b0;
          w_data_nxt    = NOP_WORD;
          w_ready_nxt   = 1'b1;
          w_err_nxt     = 1'b1;
          w_state_nxt   = RESP;
        end else begin
          w_wait_nxt = r_wait + 1'b1;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
`ifdef INST_PREFETCH_EN
        if (r_hit) begin
          w_data_nxt  = w_buf_rdata;
          w_ready_nxt = 1'b1;
          w_hit_nxt   = 1'b0;
        end
        // Successful responses chain straight into the next-word prefetch.
        if (r_ok) begin
          w_mem_req_nxt  = 1'b1;
          w_mem_addr_nxt = {r_cur_word + c_word_w'(1), 2'b00};
          w_wait_nxt     = '0;
          w_ok_nxt       = 1'b0;
          w_state_nxt    = PREF;
        end
`endif
      end
`ifdef INST_PREFETCH_EN
      PREF: begin
        if (inst_mem_read_en && !r_pend) begin
          w_pend_nxt      = 1'b1;
          w_pend_addr_nxt = inst_addr;
          w_ready_nxt     = 1'b0;
        end
        if (mem_ack) begin
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = IDLE;
          w_buf_load    = !w_req_go ||
                          (w_req_addr[c_addr_w-1:2] == r_mem_addr[c_addr_w-1:2]);
        end else if (r_wait == c_wait_last) begin
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = IDLE;
          w_buf_inv     = 1'b1;
        end else begin
          w_wait_nxt = r_wait + 1'b1;
        end
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_data     <= NOP_WORD;
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
      r_wait     <= '0;
`ifdef INST_PREFETCH_EN
      r_cur_word  <= '0;
      r_ok        <= 1'b0;
      r_hit       <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_addr <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_mem_req  <= w_mem_req_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_data     <= w_data_nxt;
      r_ready    <= w_ready_nxt;
      r_err      <= w_err_nxt;
      r_wait     <= w_wait_nxt;
`ifdef INST_PREFETCH_EN
      r_cur_word  <= w_cur_word_nxt;
      r_ok        <= w_ok_nxt;
      r_hit       <= w_hit_nxt;
      r_pend      <= w_pend_nxt;
      r_pend_addr <= w_pend_addr_nxt;
`endif
    end
  end

  assign inst_data      = r_data;
  assign inst_mem_ready = r_ready;
  assign fetch_err      = r_err;
  assign mem_req        = r_mem_req;
  assign mem_addr       = r_mem_addr;

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_resp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_inst_mem_resp                                                     |
// | Directed self-checking bench for inst_mem_resp (MAX_WAIT = 8).       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_inst_mem_resp;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        read_en = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] inst_data;
  logic        ready;
  logic        err;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  inst_mem_resp #(.MAX_WAIT(8), .NOP_WORD(NOP)) dut (
    .clk              (clk),
    .rst              (rst),
    .inst_mem_read_en (read_en),
    .inst_addr        (addr),
    .inst_data        (inst_data),
    .inst_mem_ready   (ready),
    .fetch_err        (err),
    .mem_req          (mem_req),
    .mem_addr         (mem_addr),
    .mem_rdata        (mem_rdata),
    .mem_ack          (mem_ack)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Acknowledge any trailing prefetch so the next test starts from IDLE.
  task automatic drain;
    for (int i = 0; i < 4; i++) begin
      if (mem_req === 1'b1) begin
        mem_ack = 1'b1; mem_rdata = 32'h0; tick; mem_ack = 1'b0;
        tick;
        return;
      end
      tick;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick; tick;
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", ready); end
    n_cmp++; if (inst_data !== NOP) begin n_bad++; $display("FAIL reset_data: got %h want %h", inst_data, NOP); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    rst = 1'b1;
    tick;
  endtask

  task automatic test_miss;
    read_en = 1'b1; addr = 32'h0;
    tick;
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL miss_t1_ready: got %b want 0", ready); end
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL miss_t1_req: got %b want 1", mem_req); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL miss_t1_addr: got %h want 0", mem_addr); end
    // New requests while fetching must be ignored.
    addr = 32'h80;
    for (int i = 0; i < 2; i++) begin
      tick;
      n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin n_bad++; $display("FAIL miss_hold: got req=%b addr=%h want req=1 addr=0", mem_req, mem_addr); end
    end
    read_en = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
    tick;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL miss_ready: got %b want 1", ready); end
    n_cmp++; if (inst_data !== 32'h0050_0093) begin n_bad++; $display("FAIL miss_data: got %h want 00500093", inst_data); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL miss_err: got %b want 0", err); end
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL miss_req_drop: got %b want 0", mem_req); end
    tick;
    n_cmp++; if (inst_data !== 32'h0050_0093 || ready !== 1'b1) begin n_bad++; $display("FAIL miss_stable: got %h/%b want 00500093/1", inst_data, ready); end
    drain;
  endtask

  task automatic test_misaligned;
    read_en = 1'b1; addr = 32'h0000_0102;
    tick;
    read_en = 1'b0;
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL misal_req: got %b want 0", mem_req); end
    n_cmp++; if (inst_data !== NOP) begin n_bad++; $display("FAIL misal_data: got %h want %h", inst_data, NOP); end
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL misal_ready: got %b want 1", ready); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL misal_err: got %b want 1", err); end
    tick;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL misal_err_pulse: got %b want 0", err); end
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL misal_no_req: got %b want 0", mem_req); end
    tick;
  endtask

  task automatic test_timeout;
    int cnt;
    // Seed non-NOP data so the timeout response is distinguishable.
    read_en = 1'b1; addr = 32'h0000_0008;
    tick;
    read_en = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678; tick; mem_ack = 1'b0;
    drain;
    read_en = 1'b1; addr = 32'h0000_0020;
    tick;
    read_en = 1'b0;
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL to_t1_ready: got %b want 0", ready); end
    cnt = 0;
    while (mem_req === 1'b1 && cnt < 20) begin
      cnt++;
      tick;
    end
    n_cmp++; if (cnt !== 8) begin n_bad++; $display("FAIL to_req_cycles: got %0d want 8", cnt); end
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL to_ready: got %b want 1", ready); end
    n_cmp++; if (inst_data !== NOP) begin n_bad++; $display("FAIL to_data: got %h want %h", inst_data, NOP); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL to_err: got %b want 1", err); end
    tick;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL to_err_pulse: got %b want 0", err); end
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick;
    mem_ack = 1'b0;
    tick;
    n_cmp++; if (inst_data !== NOP || ready !== 1'b1 || mem_req !== 1'b0) begin n_bad++; $display("FAIL to_stray_ack: got %h/%b/%b want %h/1/0", inst_data, ready, mem_req, NOP); end
  endtask

  task automatic test_reset_mid;
    read_en = 1'b1; addr = 32'h0000_0030;
    tick;
    read_en = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001; tick; mem_ack = 1'b0;
    n_cmp++; if (inst_data !== 32'hCAFE_0001) begin n_bad++; $display("FAIL rm_pre_data: got %h want cafe0001", inst_data); end
    drain;
    read_en = 1'b1; addr = 32'h0000_0038;
    tick;
    read_en = 1'b0;
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rm_req: got %b want 1", mem_req); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rm_req_async: got %b want 0", mem_req); end
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL rm_ready: got %b want 0", ready); end
    n_cmp++; if (inst_data !== NOP) begin n_bad++; $display("FAIL rm_data: got %h want %h", inst_data, NOP); end
    #2 rst = 1'b1;
    tick;
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rm_after: got %b want 0", mem_req); end
  endtask

`ifdef INST_PREFETCH_EN
  task automatic test_prefetch_hit;
    read_en = 1'b1; addr = 32'h0000_0010;
    tick;
    read_en = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hAAAA_0010; tick; mem_ack = 1'b0;
    n_cmp++; if (inst_data !== 32'hAAAA_0010) begin n_bad++; $display("FAIL pf_miss_data: got %h want aaaa0010", inst_data); end
    tick;
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h14) begin n_bad++; $display("FAIL pf_req: got %b/%h want 1/00000014", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'hBBBB_0014; tick; mem_ack = 1'b0;
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL pf_done: got %b want 0", mem_req); end
    read_en = 1'b1; addr = 32'h0000_0014;
    tick;
    read_en = 1'b0;
    n_cmp++; if (ready !== 1'b0 || mem_req !== 1'b0) begin n_bad++; $display("FAIL hit_t1: got ready=%b req=%b want 0/0", ready, mem_req); end
    tick;
    n_cmp++; if (ready !== 1'b1 || inst_data !== 32'hBBBB_0014) begin n_bad++; $display("FAIL hit_t2: got %b/%h want 1/bbbb0014", ready, inst_data); end
    n_cmp++; if (mem_addr === 32'h14) begin n_bad++; $display("FAIL hit_refetch: got addr %h want not 00000014", mem_addr); end
    drain;
  endtask

  task automatic test_prefetch_redirect;
    read_en = 1'b1; addr = 32'h0000_0010;
    tick;
    read_en = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hAAAA_0010; tick; mem_ack = 1'b0;
    tick;
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h14) begin n_bad++; $display("FAIL rd_pref: got %b/%h want 1/00000014", mem_req, mem_addr); end
    read_en = 1'b1; addr = 32'h0000_0040;
    tick;
    read_en = 1'b0;
    n_cmp++; if (ready !== 1'b0 || mem_addr !== 32'h14) begin n_bad++; $display("FAIL rd_wait: got %b/%h want 0/00000014", ready, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'hBBBB_0014; tick; mem_ack = 1'b0;
    n_cmp++; if (mem_req !== 1'b0 || ready !== 1'b0) begin n_bad++; $display("FAIL rd_gap: got req=%b ready=%b want 0/0", mem_req, ready); end
    tick;
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin n_bad++; $display("FAIL rd_miss: got %b/%h want 1/00000040", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'hCCCC_0040; tick; mem_ack = 1'b0;
    n_cmp++; if (ready !== 1'b1 || inst_data !== 32'hCCCC_0040) begin n_bad++; $display("FAIL rd_data: got %b/%h want 1/cccc0040", ready, inst_data); end
    drain;
  endtask
`endif

  initial begin
    test_reset;
    test_miss;
    test_misaligned;
    test_timeout;
    test_reset_mid;
`ifdef INST_PREFETCH_EN
    test_prefetch_hit;
    test_prefetch_redirect;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_mem_resp.md
INST_MEM_RESP -- requirements
Module: inst_mem_resp

Interface
REQ-001 Parameter MAX_WAIT, default 255, is the maximum number of cycles the block waits for mem_ack before reporting a timeout.
REQ-002 Parameter NOP_WORD, default 32'h00000013, is the instruction word driven on inst_data when no valid data is held.
REQ-003 Port clk, input, 1: clock; the block is rising-edge triggered.
REQ-004 Port rst, input, 1: reset, asynchronous, active-low.
REQ-005 Port inst_mem_read_en, input, 1: fetch request.
REQ-006 Port inst_addr, input, MAX_BIT_POS+1 (32): fetch byte address.
REQ-007 Port inst_data, output, 32: returned instruction word.
REQ-008 Port inst_mem_ready, output, 1: inst_data is valid for the last accepted request.
REQ-009 Port fetch_err, output, 1: one-cycle pulse, coincident with the first inst_mem_ready cycle of a failed response.
REQ-010 Ports toward backing memory: mem_req, output, 1; mem_addr, output, 32 (word-aligned); mem_rdata, input, 32; mem_ack, input, 1.

Function
REQ-011 State machine SHALL have states IDLE, FETCH (mem_req high, waiting for mem_ack), RESP (one-cycle data update) and PREF (prefetch in flight, macro only).
REQ-012 A request SHALL be accepted only on a rising edge where inst_mem_read_en=1 and the state is IDLE; inst_addr is sampled on that edge only.
REQ-013 While not IDLE, inst_mem_read_en and inst_addr SHALL be ignored; a jump redirect is re-requested by the fetch unit after inst_mem_ready rises.
REQ-014 inst_mem_ready SHALL go low on the accepting edge and stay low until the response is loaded.
REQ-015 Miss path: mem_req=1 with mem_addr={addr[31:2],2'b00} from cycle T+1 after acceptance until the edge sampling mem_ack=1; mem_rdata is captured on that edge.
REQ-016 inst_data and inst_mem_ready=1 SHALL appear in the cycle after the mem_ack edge, so minimum miss latency is 2 cycles plus the wait states.
REQ-017 inst_data and inst_mem_ready SHALL stay stable until the next accepted request.
REQ-018 If addr[1:0]!=0, no memory access SHALL occur: inst_data=NOP_WORD, ready=1 and fetch_err=1 in cycle T+1.
REQ-019 If mem_ack has not arrived after MAX_WAIT cycles of mem_req, mem_req SHALL drop; the response is inst_data=NOP_WORD, ready=1, fetch_err=1; a late mem_ack in IDLE is ignored.
REQ-020 mem_req SHALL never be asserted in two consecutive transactions without at least one low cycle between them.

Reset
REQ-021 Reset values: inst_mem_ready=0, inst_data=NOP_WORD, fetch_err=0, mem_req=0, mem_addr=0, state=IDLE, prefetch buffer invalid.
REQ-022 Reset asserted mid-transaction SHALL drop mem_req immediately (asynchronously) and discard the pending data.

Configuration
REQ-023 Macro INST_PREFETCH_EN: when defined, after each completed miss or hit the block SHALL enter PREF and fetch addr+4 into a one-entry buffer (tag plus data plus valid); the address wraps modulo 2^32.
REQ-024 With INST_PREFETCH_EN, a request whose word address matches the valid buffer tag SHALL be answered from the buffer: ready=0 in T+1, data with ready=1 in T+2, no mem_req.
REQ-025 With INST_PREFETCH_EN, a request arriving during PREF with a matching tag SHALL wait for mem_ack and then respond as a hit; a request with a non-matching tag SHALL wait for mem_ack, discard the data, then start a miss.
REQ-026 With INST_PREFETCH_EN, the buffer SHALL be invalidated on a prefetch timeout.
REQ-027 Without INST_PREFETCH_EN, the PREF state and the buffer SHALL not exist; every request is a miss.

Structure
REQ-028 The shared package SHALL hold the state encoding, NOP_WORD, and the address width taken from MAX_BIT_POS in config.v.
REQ-029 The prefetch buffer SHALL be the sub-module inst_prefetch_buf (ports: load, tag, data, lookup address, hit, invalidate) and is instantiated only under INST_PREFETCH_EN.

Verification
REQ-030 Reset release, read_en=1, inst_addr=0x00000000, mem_ack 3 cycles after mem_req with mem_rdata=0x00500093 -> ready=1 and inst_data=0x00500093 one cycle after the ack, fetch_err=0.
REQ-031 Request inst_addr=0x00000102 -> no mem_req, inst_data=0x00000013, ready=1 and fetch_err=1 in cycle T+1.
REQ-032 mem_ack withheld, MAX_WAIT=8 -> mem_req drops after 8 cycles, inst_data=0x00000013, fetch_err pulse; a later stray mem_ack causes no change.
REQ-033 INST_PREFETCH_EN, miss at 0x00000010, then request 0x00000014 after PREF completes -> exactly one mem_req at 0x00000014, ready=1 in T+2, no extra mem_req.
REQ-034 INST_PREFETCH_EN, request 0x00000040 during PREF of 0x00000014 -> wait for the ack, then mem_req at 0x00000040, returned data equals the 0x00000040 word.
REQ-035 rst low while mem_req=1 -> mem_req=0 in the same cycle, ready=0, inst_data=0x00000013.
